a2d_rr_intf: RTL and testbench

SPI master between the Segway core and the ADC128S converter. Each `nxt` pulse triggers one conversion of the next channel in a fixed round-robin: left load cell, then right load cell, then battery. Each result is held in its own 12-bit register, which feeds the rider-presence/steer-enable logic and the low-battery piezo logic. The block drives the A2D_SS_n/A2D_SCLK/A2D_MOSI/A2D_MISO pins of the Segway top level.

---
 rtl/a2d_rr_intf.sv | 103 ++++++++++
 tb/tb_a2d_rr_intf.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/a2d_rr_intf.sv
// a2d_rr_intf: SPI master polling the ADC128S round-robin (left load cell, right load cell, battery).
// Each conversion is two 16-bit frames: the first sets the channel, the second reads its result.
module a2d_rr_intf #(
  parameter logic [2:0] LFT_CH = 3'd0,
  parameter logic [2:0] RGHT_CH = 3'd4,
  parameter logic [2:0] BATT_CH = 3'd5,
  parameter int DIV_W = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nxt,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] batt,
  output logic        cnv_cmplt,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);
  typedef enum logic [2:0] {IDLE, TX1, GAP, TX2, DONE} state_t;
  localparam logic [1:0] P_LFT = 2'd0, P_RGHT = 2'd1, P_BATT = 2'd2;
  localparam logic [DIV_W-1:0] DIV_LD = {2'b10, {(DIV_W-2){1'b1}}};
  localparam logic [DIV_W-1:0] DIV_SMP = {1'b0, {(DIV_W-1){1'b1}}};
  localparam logic [DIV_W-1:0] DIV_SFT = '1;
  state_t state_q, state_d;
  logic [1:0] rr_q;
  logic [15:0] shft_q, shft_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [4:0] cnt_q, cnt_d;
  logic miso_q, cnv_q;
  logic [11:0] lft_q, rght_q, batt_q;
  logic tx, smp, sft, fin, done;
  logic [2:0] ch;
  logic [15:0] cmd;
  assign tx = (state_q == TX1) || (state_q == TX2);
  assign smp = tx && (div_q == DIV_SMP);
  assign sft = tx && (div_q == DIV_SFT);
  // the first all-ones divider value precedes the first SCLK fall, so 17 events carry 16 shifts
  assign fin = sft && (cnt_q == 5'd16);
  assign done = state_q == DONE;
  assign ch = rr_q == P_LFT ? LFT_CH : rr_q == P_RGHT ? RGHT_CH : BATT_CH;
  assign cmd = {2'b00, ch, 11'h000};
  assign SS_n = !tx;
  assign SCLK = tx ? div_q[DIV_W-1] : 1'b1;
  assign MOSI = shft_q[15];
  assign lft_ld = lft_q;
  assign rght_ld = rght_q;
  assign batt = batt_q;
  assign cnv_cmplt = cnv_q;
  always_comb begin
    state_d = state_q;
    shft_d = shft_q;
    div_d = div_q + 1'b1;
    cnt_d = cnt_q;
    if (sft) begin
      cnt_d = cnt_q + 5'd1;
      if (cnt_q != 5'd0) shft_d = {shft_q[14:0], miso_q};
    end
    case (state_q)
      IDLE: if (nxt) begin
        state_d = TX1;
        shft_d = cmd;
        div_d = DIV_LD;
        cnt_d = 5'd0;
      end
      TX1: if (fin) state_d = GAP;
      GAP: begin
        state_d = TX2;
        shft_d = cmd;
        div_d = DIV_LD;
        cnt_d = 5'd0;
      end
      TX2: if (fin) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q <= P_LFT;
      shft_q <= '0;
      div_q <= DIV_LD;
      cnt_q <= '0;
      miso_q <= 1'b0;
      cnv_q <= 1'b0;
      lft_q <= '0;
      rght_q <= '0;
      batt_q <= '0;
    end else begin
      state_q <= state_d;
      shft_q <= shft_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
      if (smp) miso_q <= MISO;
      cnv_q <= done;
      if (done) rr_q <= rr_q == P_LFT ? P_RGHT : rr_q == P_RGHT ? P_BATT : P_LFT;
      if (done && rr_q == P_LFT) lft_q <= shft_q[11:0];
      if (done && rr_q == P_RGHT) rght_q <= shft_q[11:0];
      if (done && rr_q == P_BATT) batt_q <= shft_q[11:0];
    end
  end
endmodule

// File: tb/tb_a2d_rr_intf.sv
// tb_a2d_rr_intf: ADC128S pin model plus a scoreboard of expected result-register writes.
module tb_a2d_rr_intf;
  logic clk = 1'b0, rst_n = 1'b0, nxt = 1'b0, MISO = 1'b0;
  logic [11:0] lft_ld, rght_ld, batt;
  logic cnv_cmplt, SS_n, SCLK, MOSI;
  always #5 clk = ~clk;
  a2d_rr_intf dut (
    .clk(clk), .rst_n(rst_n), .nxt(nxt), .lft_ld(lft_ld), .rght_ld(rght_ld), .batt(batt),
    .cnv_cmplt(cnv_cmplt), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO)
  );
  int checks = 0, failures = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  typedef struct packed {logic [1:0] sel; logic [11:0] val;} exp_t;
  exp_t sb[$];
  exp_t e, p;
  logic [11:0] lft_set = 12'h130, rght_set = 12'h190, batt_set = 12'hC00;
  logic [11:0] exp_l = '0, exp_r = '0, exp_b = '0;
  logic [1:0] tb_ptr = '0;
  logic [2:0] exp_ch = '0, prev_ch = '0;
  logic [15:0] cmd_sh = '0, word = '0;
  logic sclk_p = 1'b1, ssn_p = 1'b1, mosi_p = 1'b0;
  bit mon_en = 1'b0;
  int frm = 0, hi_len = 0, lo_len = 0, rises = 0, viol = 0, cnv_cnt = 0, idx = 0;
  function automatic logic [11:0] ch_val(input logic [2:0] c);
    return c == 3'd0 ? lft_set : c == 3'd4 ? rght_set : c == 3'd5 ? batt_set : 12'h000;
  endfunction
  always @(negedge clk) begin
    if (ssn_p && !SS_n) begin
      if (mon_en && frm == 1) chk("gap_len", hi_len, 1);
      idx = 0;
      lo_len = 0;
      rises = 0;
      word = {4'h0, ch_val(prev_ch)};
      MISO = 1'b0;
    end
    if (!ssn_p && SS_n) begin
      prev_ch = cmd_sh[13:11];
      if (mon_en) begin
        chk("ss_low_len", lo_len, 521);
        chk("sclk_rises", rises, 16);
        chk("cmd_bits", cmd_sh[15:11], {2'b00, exp_ch});
      end
      frm++;
      hi_len = 0;
    end
    if (SS_n) hi_len++;
    else lo_len++;
    if (!ssn_p && !SS_n && sclk_p && !SCLK && idx < 16) begin
      MISO = word[15-idx];
      idx++;
    end
    if (!ssn_p && !SS_n && !sclk_p && SCLK) begin
      rises++;
      cmd_sh = {cmd_sh[14:0], MOSI};
    end
    if (!ssn_p && !SS_n && sclk_p && SCLK && MOSI !== mosi_p) viol++;
    if (ssn_p && SS_n && SCLK !== sclk_p) viol++;
    if (cnv_cmplt) begin
      cnv_cnt++;
      if (sb.size() == 0) chk("spurious_cnv", 1, 0);
      else begin
        e = sb.pop_front();
        if (e.sel == 2'd0) exp_l = e.val;
        if (e.sel == 2'd1) exp_r = e.val;
        if (e.sel == 2'd2) exp_b = e.val;
        chk("lft_ld", lft_ld, exp_l);
        chk("rght_ld", rght_ld, exp_r);
        chk("batt", batt, exp_b);
      end
    end
    sclk_p = SCLK;
    ssn_p = SS_n;
    mosi_p = MOSI;
  end
  task automatic convert(input bit spam);
    int lat, c0;
    exp_ch = tb_ptr == 2'd0 ? 3'd0 : tb_ptr == 2'd1 ? 3'd4 : 3'd5;
    p.sel = tb_ptr;
    p.val = ch_val(exp_ch);
    sb.push_back(p);
    tb_ptr = tb_ptr == 2'd2 ? 2'd0 : tb_ptr + 2'd1;
    frm = 0;
    c0 = cnv_cnt;
    lat = 0;
    nxt = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      nxt = spam && (lat % 100 == 0);
    end while (!cnv_cmplt && lat < 1200);
    nxt = 1'b0;
    chk("latency", lat, 1045);
    repeat (3) @(negedge clk);
    chk("cnv_once", cnv_cnt - c0, 1);
  endtask
  initial begin
    int c0;
    repeat (3) @(negedge clk);
    chk("rst_ss_n", SS_n, 1);
    chk("rst_sclk", SCLK, 1);
    chk("rst_mosi", MOSI, 0);
    chk("rst_cnv", cnv_cmplt, 0);
    chk("rst_lft", lft_ld, 0);
    chk("rst_rght", rght_ld, 0);
    chk("rst_batt", batt, 0);
    rst_n = 1'b1;
    @(negedge clk);
    nxt = 1'b1;
    @(negedge clk);
    nxt = 1'b0;
    repeat (700) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_ss_n", SS_n, 1);
    chk("abort_sclk", SCLK, 1);
    c0 = cnv_cnt;
    repeat (1100) @(negedge clk);
    chk("abort_no_cnv", cnv_cnt - c0, 0);
    chk("abort_lft", lft_ld, 0);
    mon_en = 1'b1;
    repeat (3) convert(1'b0);
    lft_set = 12'h200;
    convert(1'b0);
    convert(1'b1);
    for (int i = 0; i < 25; i++) begin
      lft_set = 12'($urandom);
      rght_set = 12'($urandom);
      batt_set = 12'($urandom);
      convert(i % 7 == 3);
    end
    chk("mosi_sclk_viol", viol, 0);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
